// File: rtl/enc_serializer.sv
// Sequential priority encoder: emits the index of every set bit of a vector.
// Define ENC_SERIALIZER_ZERO_REPORT_EN to emit a zero-flagged beat for all-zero vectors.
module enc_serializer #(
    parameter int N   = 8,
    parameter bit DIR = 1'b0,
    localparam int IW = $clog2(N)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [N-1:0]  vec_i,
    input  logic          vec_valid_i,
    output logic          vec_ready_o,
    output logic [IW-1:0] idx_o,
    output logic          idx_valid_o,
    input  logic          idx_ready_i,
    output logic          idx_last_o,
    output logic          idx_zero_o
);

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   pending_q, pending_d;
    logic [IW-1:0]  sel_idx;
    logic [N-1:0]   sel_mask;
    logic           one_left;

`ifdef ENC_SERIALIZER_ZERO_REPORT_EN
    logic zero_q, zero_d;
`endif

    // Scan so the winning bit is written last.
    always_comb begin
        int k;
        sel_idx  = '0;
        sel_mask = '0;
        k        = 0;
        for (int i = 0; i < N; i++) begin
            k = DIR ? i : N - 1 - i;
            if (pending_q[k]) begin
                sel_idx     = IW'(k);
                sel_mask    = '0;
                sel_mask[k] = 1'b1;
            end
        end
    end

    // An empty pending (zero report) also counts as the final beat.
    assign one_left = (pending_q & (pending_q - N'(1))) == '0;

    assign vec_ready_o = (state_q == IDLE);
    assign idx_valid_o = (state_q == EMIT);
    assign idx_o       = idx_valid_o ? sel_idx : '0;
    assign idx_last_o  = idx_valid_o & one_left;

`ifdef ENC_SERIALIZER_ZERO_REPORT_EN
    assign idx_zero_o  = idx_valid_o & zero_q;
`else
    assign idx_zero_o  = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
`ifdef ENC_SERIALIZER_ZERO_REPORT_EN
        zero_d    = zero_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (vec_valid_i) begin
                    if (vec_i != '0) begin
                        pending_d = vec_i;
                        state_d   = EMIT;
                    end
`ifdef ENC_SERIALIZER_ZERO_REPORT_EN
                    else begin
                        zero_d  = 1'b1;
                        state_d = EMIT;
                    end
`endif
                end
            end
            EMIT: begin
                if (idx_ready_i) begin
                    pending_d = pending_q & ~sel_mask;
                    if (one_left) begin
                        state_d = IDLE;
`ifdef ENC_SERIALIZER_ZERO_REPORT_EN
                        zero_d  = 1'b0;
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
        end
    end

`ifdef ENC_SERIALIZER_ZERO_REPORT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            zero_q <= 1'b0;
        end else begin
            zero_q <= zero_d;
        end
    end
`endif

endmodule
